xsizer_buf: RTL and testbench

Buffered, handshaked data-width converter between a DWI-bit request stream and a DWO-bit request stream, the flow-controlled successor of the combinational sizer in the switch datapath. Upsizing packs several narrow beats into one wide beat. Downsizing splits one wide beat into several narrow beats. Both directions run at one beat per cycle under valid/ready backpressure. It sits between a switch port and a target or initiator whose bus width differs.

---
 rtl/xsizer_buf_if.sv | 16 +
 rtl/xsizer_buf.sv | 224 ++++++++++++++++++++++
 tb/tb_xsizer_buf.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xsizer_buf_if.sv
// Valid/ready beat bus (address, data, byte strobes, last) shared by both sides of xsizer_buf.
// The master drives the beat; the slave returns rdy.
interface xsizer_buf_if #(
    parameter int AW = 19,
    parameter int DW = 32
);
    logic            vld;
    logic            rdy;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [DW/8-1:0] strb;
    logic            last;

    modport master (output vld, adr, dat, strb, last, input rdy);
    modport slave  (input vld, adr, dat, strb, last, output rdy);
endinterface

// File: rtl/xsizer_buf.sv
// Buffered valid/ready width converter: packs narrow beats (DWI<DWO), splits wide beats (DWI>DWO), or slices.
// Optional XSIZER_SKIP_EMPTY_EN: the downsizer skips lanes whose strobes are all zero.
module xsizer_buf #(
    parameter int AW  = 19,
    parameter int DWI = 32,
    parameter int DWO = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    xsizer_buf_if.slave  in_if,
    xsizer_buf_if.master out_if
);
    generate
        if (DWI < DWO) begin : g_up
            localparam int R   = DWO / DWI;
            localparam int LW  = $clog2(R);
            localparam int LSB = $clog2(DWI / 8);
            localparam int MSB = $clog2(DWO / 8) - 1;
            localparam int SI  = DWI / 8;
            localparam logic [AW-1:0] LANE_MASK = {{(AW-MSB-1){1'b0}}, {(MSB+1){1'b1}}};

            typedef enum logic {FILL, FULL} state_t;
            state_t           state_q, state_d;
            logic [DWO-1:0]   dat_q, dat_d;
            logic [DWO/8-1:0] strb_q, strb_d;
            logic [AW-1:0]    adr_q, adr_d;
            logic             last_q, last_d;
            logic             open_q, open_d;
            logic [LW-1:0]    lane;
            logic             acc, hs_out;

            assign lane      = in_if.adr[MSB:LSB];
            assign in_if.rdy = !rst_i && ((state_q == FILL) || out_if.rdy);
            assign acc       = in_if.vld && in_if.rdy;
            assign hs_out    = (state_q == FULL) && out_if.rdy;

            always_comb begin
                state_d = state_q;
                dat_d   = dat_q;
                strb_d  = strb_q;
                adr_d   = adr_q;
                last_d  = last_q;
                open_d  = open_q;
                if (hs_out) begin
                    state_d = FILL;
                    open_d  = 1'b0;
                end
                if (acc) begin
                    // open_q is never set in FULL, so an accept there always starts a fresh group
                    if (!open_q) begin
                        dat_d  = '0;
                        strb_d = '0;
                        adr_d  = in_if.adr;
                    end
                    dat_d[lane*DWI +: DWI] = in_if.dat;
                    strb_d[lane*SI +: SI]  = in_if.strb;
                    open_d = 1'b1;
                    if ((lane == LW'(R - 1)) || in_if.last) begin
                        state_d = FULL;
                        last_d  = in_if.last;
                        open_d  = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q <= FILL;
                    dat_q   <= '0;
                    strb_q  <= '0;
                    adr_q   <= '0;
                    last_q  <= 1'b0;
                    open_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    dat_q   <= dat_d;
                    strb_q  <= strb_d;
                    adr_q   <= adr_d;
                    last_q  <= last_d;
                    open_q  <= open_d;
                end
            end

            assign out_if.vld  = (state_q == FULL);
            assign out_if.dat  = dat_q;
            assign out_if.strb = strb_q;
            assign out_if.adr  = adr_q & ~LANE_MASK;
            assign out_if.last = last_q;
        end else if (DWI > DWO) begin : g_dn
            localparam int R   = DWI / DWO;
            localparam int LW  = $clog2(R);
            localparam int LSB = $clog2(DWO / 8);
            localparam int MSB = $clog2(DWI / 8) - 1;
            localparam int SO  = DWO / 8;
            localparam logic [AW-1:0] LANE_MASK = {{(AW-MSB-1){1'b0}}, {(MSB+1){1'b1}}};

            typedef enum logic {IDLE, EMIT} state_t;
            state_t           state_q, state_d;
            logic [DWI-1:0]   dat_q, dat_d;
            logic [DWI/8-1:0] strb_q, strb_d;
            logic [AW-1:0]    adr_q, adr_d;
            logic             last_q, last_d;
            logic [LW-1:0]    ptr_q, ptr_d;
            logic [LW-1:0]    start_lane, nxt_ptr;
            logic             fin, acc, hs_out;

            // fin marks the lane currently presented as the final beat of the held word
            always_comb begin
                start_lane = in_if.adr[MSB:LSB];
                nxt_ptr    = ptr_q + 1'b1;
                fin        = (ptr_q == LW'(R - 1));
`ifdef XSIZER_SKIP_EMPTY_EN
                fin = 1'b1;
                for (int l = R - 1; l >= 0; l--) begin
                    if ((LW'(l) > ptr_q) && (|strb_q[l*SO +: SO])) begin
                        nxt_ptr = LW'(l);
                        fin     = 1'b0;
                    end
                    if ((LW'(l) >= in_if.adr[MSB:LSB]) && (|in_if.strb[l*SO +: SO])) begin
                        start_lane = LW'(l);
                    end
                end
`endif
            end

            assign in_if.rdy = !rst_i && ((state_q == IDLE) || (out_if.rdy && fin));
            assign acc       = in_if.vld && in_if.rdy;
            assign hs_out    = (state_q == EMIT) && out_if.rdy;

            always_comb begin
                state_d = state_q;
                dat_d   = dat_q;
                strb_d  = strb_q;
                adr_d   = adr_q;
                last_d  = last_q;
                ptr_d   = ptr_q;
                if (hs_out) begin
                    if (fin) state_d = IDLE;
                    else     ptr_d   = nxt_ptr;
                end
                if (acc) begin
                    state_d = EMIT;
                    dat_d   = in_if.dat;
                    strb_d  = in_if.strb;
                    adr_d   = in_if.adr;
                    last_d  = in_if.last;
                    ptr_d   = start_lane;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q <= IDLE;
                    dat_q   <= '0;
                    strb_q  <= '0;
                    adr_q   <= '0;
                    last_q  <= 1'b0;
                    ptr_q   <= '0;
                end else begin
                    state_q <= state_d;
                    dat_q   <= dat_d;
                    strb_q  <= strb_d;
                    adr_q   <= adr_d;
                    last_q  <= last_d;
                    ptr_q   <= ptr_d;
                end
            end

            assign out_if.vld  = (state_q == EMIT);
            assign out_if.dat  = dat_q[ptr_q*DWO +: DWO];
            assign out_if.strb = strb_q[ptr_q*SO +: SO];
            assign out_if.adr  = (adr_q & ~LANE_MASK) | (AW'(ptr_q) << LSB);
            assign out_if.last = last_q && fin;
        end else begin : g_eq
            logic             vld_q, vld_d;
            logic [DWI-1:0]   dat_q, dat_d;
            logic [DWI/8-1:0] strb_q, strb_d;
            logic [AW-1:0]    adr_q, adr_d;
            logic             last_q, last_d;
            logic             acc;

            assign in_if.rdy = !rst_i && (!vld_q || out_if.rdy);
            assign acc       = in_if.vld && in_if.rdy;

            always_comb begin
                vld_d  = vld_q;
                dat_d  = dat_q;
                strb_d = strb_q;
                adr_d  = adr_q;
                last_d = last_q;
                if (out_if.rdy) vld_d = 1'b0;
                if (acc) begin
                    vld_d  = 1'b1;
                    dat_d  = in_if.dat;
                    strb_d = in_if.strb;
                    adr_d  = in_if.adr;
                    last_d = in_if.last;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q  <= 1'b0;
                    dat_q  <= '0;
                    strb_q <= '0;
                    adr_q  <= '0;
                    last_q <= 1'b0;
                end else begin
                    vld_q  <= vld_d;
                    dat_q  <= dat_d;
                    strb_q <= strb_d;
                    adr_q  <= adr_d;
                    last_q <= last_d;
                end
            end

            assign out_if.vld  = vld_q;
            assign out_if.dat  = dat_q;
            assign out_if.strb = strb_q;
            assign out_if.adr  = adr_q;
            assign out_if.last = last_q;
        end
    endgenerate
endmodule

// File: tb/tb_xsizer_buf.sv
// Scoreboard bench for xsizer_buf: a 32->64 upsizer and a 128->32 downsizer side by side.
// Downsizer expectations follow XSIZER_SKIP_EMPTY_EN when it is defined.
module tb_xsizer_buf;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xsizer_buf_if #(.AW(19), .DW(32))  up_in  ();
    xsizer_buf_if #(.AW(19), .DW(64))  up_out ();
    xsizer_buf_if #(.AW(19), .DW(128)) dn_in  ();
    xsizer_buf_if #(.AW(19), .DW(32))  dn_out ();

    xsizer_buf #(.AW(19), .DWI(32), .DWO(64)) u_up (
        .clk_i(clk), .rst_i(rst), .in_if(up_in), .out_if(up_out)
    );
    xsizer_buf #(.AW(19), .DWI(128), .DWO(32)) u_dn (
        .clk_i(clk), .rst_i(rst), .in_if(dn_in), .out_if(dn_out)
    );

    typedef struct {
        logic [18:0]  adr;
        logic [127:0] dat;
        logic [15:0]  strb;
        logic         last;
    } beat_t;

    beat_t up_q[$];
    beat_t dn_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic push_up(input logic [18:0] a, input logic [63:0] d, input logic [7:0] s, input logic l);
        beat_t b;
        b.adr = a; b.dat = 128'(d); b.strb = 16'(s); b.last = l;
        up_q.push_back(b);
    endtask

    task automatic push_dn(input logic [18:0] a, input logic [31:0] d, input logic [3:0] s, input logic l);
        beat_t b;
        b.adr = a; b.dat = 128'(d); b.strb = 16'(s); b.last = l;
        dn_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_up(input logic [18:0] a, input logic [31:0] d, input logic [3:0] s, input logic l);
        int   n;
        logic got;
        n = 0; got = 1'b0;
        up_in.vld = 1'b1; up_in.adr = a; up_in.dat = d; up_in.strb = s; up_in.last = l;
        while (!got && n < 50) begin
            @(negedge clk);
            got = up_in.rdy;
            tick();
            n++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL up_send_timeout got=no_accept want=accept adr=%0h", a);
        end
        up_in.vld = 1'b0;
    endtask

    task automatic send_dn(input logic [18:0] a, input logic [127:0] d, input logic [15:0] s, input logic l);
        int   n;
        logic got;
        n = 0; got = 1'b0;
        dn_in.vld = 1'b1; dn_in.adr = a; dn_in.dat = d; dn_in.strb = s; dn_in.last = l;
        while (!got && n < 50) begin
            @(negedge clk);
            got = dn_in.rdy;
            tick();
            n++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL dn_send_timeout got=no_accept want=accept adr=%0h", a);
        end
        dn_in.vld = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && up_out.vld && up_out.rdy) begin
            $display("up beat adr=%05h dat=%016h strb=%02h last=%0b", up_out.adr, up_out.dat, up_out.strb, up_out.last);
            if (up_q.size() == 0) begin
                total++; bad++;
                $display("FAIL up_unexpected got=beat adr=%0h want=none", up_out.adr);
            end else begin
                e = up_q.pop_front();
                chk("up_adr",  128'(up_out.adr),  128'(e.adr));
                chk("up_dat",  128'(up_out.dat),  e.dat);
                chk("up_strb", 128'(up_out.strb), 128'(e.strb));
                chk("up_last", 128'(up_out.last), 128'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && dn_out.vld && dn_out.rdy) begin
            $display("dn beat adr=%05h dat=%08h strb=%01h last=%0b", dn_out.adr, dn_out.dat, dn_out.strb, dn_out.last);
            if (dn_q.size() == 0) begin
                total++; bad++;
                $display("FAIL dn_unexpected got=beat adr=%0h want=none", dn_out.adr);
            end else begin
                e = dn_q.pop_front();
                chk("dn_adr",  128'(dn_out.adr),  128'(e.adr));
                chk("dn_dat",  128'(dn_out.dat),  e.dat);
                chk("dn_strb", 128'(dn_out.strb), 128'(e.strb));
                chk("dn_last", 128'(dn_out.last), 128'(e.last));
            end
        end
    end

    initial begin
        int n;
        up_in.vld = 0; up_in.adr = '0; up_in.dat = '0; up_in.strb = '0; up_in.last = 0; up_out.rdy = 1;
        dn_in.vld = 0; dn_in.adr = '0; dn_in.dat = '0; dn_in.strb = '0; dn_in.last = 0; dn_out.rdy = 1;
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_up_vld",  128'(up_out.vld),  0);
        chk("rst_up_dat",  128'(up_out.dat),  0);
        chk("rst_up_strb", 128'(up_out.strb), 0);
        chk("rst_up_adr",  128'(up_out.adr),  0);
        chk("rst_up_last", 128'(up_out.last), 0);
        chk("rst_up_rdy",  128'(up_in.rdy),   0);
        chk("rst_dn_vld",  128'(dn_out.vld),  0);
        chk("rst_dn_dat",  128'(dn_out.dat),  0);
        chk("rst_dn_adr",  128'(dn_out.adr),  0);
        chk("rst_dn_rdy",  128'(dn_in.rdy),   0);
        tick();
        rst = 1'b0;

        // Upsize two beats into one
        push_up(19'h100, 64'hBBBB_0002_AAAA_0001, 8'hFF, 1'b0);
        send_up(19'h100, 32'hAAAA_0001, 4'hF, 1'b0);
        @(negedge clk);
        chk("up_no_early", 128'(up_out.vld), 0);
        tick();
        send_up(19'h104, 32'hBBBB_0002, 4'hF, 1'b0);
        @(negedge clk);
        chk("up_latency", 128'(up_out.vld), 1);
        tick();
        @(negedge clk);
        chk("up_single_beat", 128'(up_out.vld), 0);
        tick();

        // Upsize a single upper-lane last beat
        push_up(19'h100, 64'hCCCC_0003_0000_0000, 8'hF0, 1'b1);
        send_up(19'h104, 32'hCCCC_0003, 4'hF, 1'b1);
        @(negedge clk);
        chk("up_last_latency", 128'(up_out.vld), 1);
        tick();

        // Downsize 128->32 starting at lane 2
        push_dn(19'h208, 32'hD2D2_0002, 4'hF, 1'b0);
        push_dn(19'h20C, 32'hD3D3_0003, 4'hF, 1'b1);
        send_dn(19'h208, 128'hD3D3_0003_D2D2_0002_D1D1_0001_D0D0_0000, 16'hFFFF, 1'b1);
        @(negedge clk);
        chk("dn_first_vld", 128'(dn_out.vld), 1);
        chk("dn_rdy_first", 128'(dn_in.rdy),  0);
        @(negedge clk);
        chk("dn_rdy_final", 128'(dn_in.rdy),  1);
        tick();
        @(negedge clk);
        chk("dn_done_vld", 128'(dn_out.vld), 0);
        tick();

        // Downsize back-to-back wide beats
        push_dn(19'h408, 32'hA2A2_0002, 4'hF, 1'b0);
        push_dn(19'h40C, 32'hA3A3_0003, 4'hF, 1'b0);
        push_dn(19'h50C, 32'hB3B3_0003, 4'hF, 1'b1);
        send_dn(19'h408, 128'hA3A3_0003_A2A2_0002_A1A1_0001_A0A0_0000, 16'hFFFF, 1'b0);
        send_dn(19'h50C, 128'hB3B3_0003_B2B2_0002_B1B1_0001_B0B0_0000, 16'hFFFF, 1'b1);
        @(negedge clk);
        chk("dn_no_bubble", 128'(dn_out.vld), 1);
        tick();

        // Upsizer backpressure, then release with a back-to-back accept
        up_out.rdy = 1'b0;
        push_up(19'h200, 64'h2222_0B0B_1111_0A0A, 8'hFF, 1'b0);
        send_up(19'h200, 32'h1111_0A0A, 4'hF, 1'b0);
        send_up(19'h204, 32'h2222_0B0B, 4'hF, 1'b0);
        push_up(19'h208, 64'hEEEE_000E_0000_0000, 8'hF0, 1'b1);
        up_in.vld = 1'b1; up_in.adr = 19'h20C; up_in.dat = 32'hEEEE_000E; up_in.strb = 4'hF; up_in.last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("up_bp_vld", 128'(up_out.vld), 1);
            chk("up_bp_dat", 128'(up_out.dat), 128'h2222_0B0B_1111_0A0A);
            chk("up_bp_adr", 128'(up_out.adr), 128'h200);
            chk("up_bp_rdy", 128'(up_in.rdy),  0);
            tick();
        end
        up_out.rdy = 1'b1;
        @(negedge clk);
        chk("up_release_rdy", 128'(up_in.rdy), 1);
        tick();
        up_in.vld = 1'b0;
        @(negedge clk);
        chk("up_release_next", 128'(up_out.vld), 1);
        tick();

        // Reset in the middle of a four-beat split
        push_dn(19'h600, 32'h6000_0000, 4'hF, 1'b0);
        send_dn(19'h600, 128'h6333_3333_6222_2222_6111_1111_6000_0000, 16'hFFFF, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("dn_rst_vld", 128'(dn_out.vld), 0);
        chk("dn_rst_rdy", 128'(dn_in.rdy),  0);
        chk("dn_rst_dat", 128'(dn_out.dat), 0);
        tick();
        rst = 1'b0;
        push_dn(19'h704, 32'h7111_1111, 4'hF, 1'b0);
        push_dn(19'h708, 32'h7222_2222, 4'hF, 1'b0);
        push_dn(19'h70C, 32'h7333_3333, 4'hF, 1'b0);
        send_dn(19'h704, 128'h7333_3333_7222_2222_7111_1111_7000_0000, 16'hFFFF, 1'b0);

        // Sparse and empty strobes
`ifdef XSIZER_SKIP_EMPTY_EN
        push_dn(19'h000, 32'h8000_0000, 4'hF, 1'b0);
        push_dn(19'h008, 32'h8222_2222, 4'hF, 1'b1);
        push_dn(19'h904, 32'h9111_1111, 4'h0, 1'b1);
`else
        push_dn(19'h000, 32'h8000_0000, 4'hF, 1'b0);
        push_dn(19'h004, 32'h8111_1111, 4'h0, 1'b0);
        push_dn(19'h008, 32'h8222_2222, 4'hF, 1'b0);
        push_dn(19'h00C, 32'h8333_3333, 4'h0, 1'b1);
        push_dn(19'h904, 32'h9111_1111, 4'h0, 1'b0);
        push_dn(19'h908, 32'h9222_2222, 4'h0, 1'b0);
        push_dn(19'h90C, 32'h9333_3333, 4'h0, 1'b1);
`endif
        send_dn(19'h000, 128'h8333_3333_8222_2222_8111_1111_8000_0000, 16'h0F0F, 1'b1);
        send_dn(19'h904, 128'h9333_3333_9222_2222_9111_1111_9000_0000, 16'h0000, 1'b1);

        n = 0;
        while ((up_q.size() != 0 || dn_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("up_q_empty", 128'(up_q.size()), 0);
        chk("dn_q_empty", 128'(dn_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
